// File: rtl/ram32_fifo_if.sv
// ram32_fifo_if: valid/ready bus of ram32_fifo
// master: producer/consumer side drives flush, wr_d, wr_valid, rd_ready
// slave : FIFO side drives wr_ready, rd_d, rd_valid, count, almost_full
interface ram32_fifo_if #(parameter int WIDTH = 8);
  logic             flush;
  logic [WIDTH-1:0] wr_d;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] rd_d;
  logic             rd_valid;
  logic             rd_ready;
  logic [5:0]       count;
  logic             almost_full;
  modport master (
    output flush, wr_d, wr_valid, rd_ready,
    input  wr_ready, rd_d, rd_valid, count, almost_full
  );
  modport slave (
    input  flush, wr_d, wr_valid, rd_ready,
    output wr_ready, rd_d, rd_valid, count, almost_full
  );
endinterface

// File: rtl/ram32_fifo.sv
// ram32_fifo: 32-entry first-word-fall-through FIFO on a 32xWIDTH distributed RAM
// clk, rst_n (async active-low), bus: ram32_fifo_if.slave (flush, write and read handshakes,
// count of stored words, almost_full when count >= AF_LEVEL)
module ram32_fifo #(
  parameter int               WIDTH    = 8,
  parameter int               AF_LEVEL = 28,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input logic         clk,
  input logic         rst_n,
  ram32_fifo_if.slave bus
);
  // Power-up contents only; reset leaves the array alone.
  logic [WIDTH-1:0] mem [32] = '{default: INIT};
  logic [4:0] wp, rp;
  logic [5:0] count;
  logic       wf, rf;
  assign bus.wr_ready    = rst_n && count != 6'd32;
  assign bus.rd_valid    = count != 6'd0;
  assign bus.count       = count;
  assign bus.almost_full = count >= 6'(AF_LEVEL);
  // Head word falls straight through from the asynchronous read port.
  assign bus.rd_d        = mem[rp];
  assign wf              = bus.wr_valid && bus.wr_ready;
  assign rf              = bus.rd_valid && bus.rd_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wf) wp <= wp + 5'd1;
      if (rf) rp <= rp + 5'd1;
      count <= count + 6'(wf) - 6'(rf);
    end
  always_ff @(posedge clk)
    if (wf && !bus.flush) mem[wp] <= bus.wr_d;
endmodule

// File: tb/tb_ram32_fifo.sv
// tb_ram32_fifo: randomized and directed checks of ram32_fifo against a queue model
module tb_ram32_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  ram32_fifo_if #(.WIDTH(8)) bus ();
  ram32_fifo #(.WIDTH(8), .AF_LEVEL(28), .INIT(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic step(input logic wv, input logic [7:0] d, input logic rr, input logic fl);
    logic wf, rf;
    bus.wr_valid = wv;
    bus.wr_d     = d;
    bus.rd_ready = rr;
    bus.flush    = fl;
    wf = wv && q.size() < 32;
    rf = rr && q.size() > 0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (rf) void'(q.pop_front());
      if (wf) q.push_back(d);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    bus.flush    = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 4;
    if (bus.count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b exp=0", bus.wr_ready); end
    if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost_full got=%b exp=0", bus.almost_full); end
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    total += 2;
    if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL post_reset_wr_ready got=%b exp=1", bus.wr_ready); end
    if (bus.count !== 6'd0) begin bad++; $display("FAIL post_reset_count got=%0d exp=0", bus.count); end
  endtask
  task automatic test_reset_mid_burst();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    total++;
    if (bus.count !== 6'd5) begin bad++; $display("FAIL burst_count got=%0d exp=5", bus.count); end
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (bus.count !== 6'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
    if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_rd_valid got=%b exp=0", bus.rd_valid); end
    if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL midrst_wr_ready got=%b exp=0", bus.wr_ready); end
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_wr_ready got=%b exp=1", bus.wr_ready); end
    step(1'b1, 8'h77, 1'b0, 1'b0);
    total += 3;
    if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL midrst_rd_valid2 got=%b exp=1", bus.rd_valid); end
    if (bus.rd_d !== 8'h77) begin bad++; $display("FAIL midrst_first_read got=%h exp=77", bus.rd_d); end
    if (bus.count !== 6'd1) begin bad++; $display("FAIL midrst_count2 got=%0d exp=1", bus.count); end
  endtask
  task automatic test_fill_drain();
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      total += 2;
      if (bus.count !== 6'(q.size())) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, q.size()); end
      if (bus.almost_full !== (q.size() >= 28)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, bus.almost_full, q.size() >= 28); end
    end
    total += 2;
    if (bus.count !== 6'd32) begin bad++; $display("FAIL full_count got=%0d exp=32", bus.count); end
    if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready got=%b exp=0", bus.wr_ready); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (bus.rd_d !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, bus.rd_d, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++;
    if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL drained_rd_valid got=%b exp=0", bus.rd_valid); end
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.rd_d !== 8'(8'hA0 + i)) begin bad++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, bus.rd_d, 8'(8'hA0 + i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask
  task automatic test_full_rw();
    while (q.size() < 32) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    total++;
    if (bus.rd_d !== q[0]) begin bad++; $display("FAIL fullrw_head got=%h exp=%h", bus.rd_d, q[0]); end
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    total += 2;
    if (bus.count !== 6'd31) begin bad++; $display("FAIL fullrw_count got=%0d exp=31", bus.count); end
    if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL fullrw_wr_ready got=%b exp=1", bus.wr_ready); end
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    total++;
    if (bus.count !== 6'd32) begin bad++; $display("FAIL fullrw_count2 got=%0d exp=32", bus.count); end
    while (q.size() > 0) begin
      total++;
      if (bus.rd_d !== q[0]) begin bad++; $display("FAIL fullrw_drain got=%h exp=%h", bus.rd_d, q[0]); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask
  task automatic test_empty_write();
    total++;
    if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL empty_rd_valid got=%b exp=0", bus.rd_valid); end
    step(1'b1, 8'h5C, 1'b1, 1'b0);
    total += 3;
    if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL empty_wr_rd_valid got=%b exp=1", bus.rd_valid); end
    if (bus.rd_d !== 8'h5C) begin bad++; $display("FAIL empty_wr_data got=%h exp=5c", bus.rd_d); end
    if (bus.count !== 6'd1) begin bad++; $display("FAIL empty_wr_count got=%0d exp=1", bus.count); end
  endtask
  task automatic test_flush();
    while (q.size() < 5) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    total += 2;
    if (bus.count !== 6'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL flush_rd_valid got=%b exp=0", bus.rd_valid); end
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    total += 2;
    if (bus.rd_d !== 8'h3C) begin bad++; $display("FAIL flush_readback got=%h exp=3c", bus.rd_d); end
    if (bus.count !== 6'd1) begin bad++; $display("FAIL flush_count2 got=%0d exp=1", bus.count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_stream();
    int wp_pct, rp_pct;
    wp_pct = 50;
    rp_pct = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 400 == 0) begin
        wp_pct = $urandom_range(10, 95);
        rp_pct = $urandom_range(10, 95);
      end
      total += 4;
      if (bus.count !== 6'(q.size())) begin bad++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, bus.count, q.size()); end
      if (bus.wr_ready !== (q.size() < 32)) begin bad++; $display("FAIL stream_wr_ready c=%0d got=%b exp=%b", c, bus.wr_ready, q.size() < 32); end
      if (bus.rd_valid !== (q.size() > 0)) begin bad++; $display("FAIL stream_rd_valid c=%0d got=%b exp=%b", c, bus.rd_valid, q.size() > 0); end
      if (bus.almost_full !== (q.size() >= 28)) begin bad++; $display("FAIL stream_af c=%0d got=%b exp=%b", c, bus.almost_full, q.size() >= 28); end
      if (q.size() > 0) begin
        total++;
        if (bus.rd_d !== q[0]) begin bad++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, bus.rd_d, q[0]); end
      end
      step($urandom_range(0, 99) < wp_pct, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < rp_pct, 1'b0);
    end
  endtask
  initial begin
    bus.flush    = 1'b0;
    bus.wr_d     = 8'h00;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_reset_mid_burst();
    test_fill_drain();
    test_full_rw();
    test_empty_write();
    test_flush();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
